// File: rtl/mii_pkg.sv
// Shared types and constants for the MII/RMII/GMII receive deframer.
// Sub-word width is a parameter of the users; helpers here take it as an argument.
package mii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam int         LAST_TAG_BIT  = 8;

    function automatic int subwords_per_byte(input int data_width);
        return 8 / data_width;
    endfunction

endpackage

// File: rtl/mii_sample_strobe.sv
// Sample strobe generator: every clock at full speed, or one strobe per SLOW_DIVIDE
// clocks (centred in the sub-word) in 10 Mb/s mode, phase-locked to the rising edge of DV.
module mii_sample_strobe #(
    parameter int SLOW_DIVIDE = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic slow_mode,
    input  logic rx_dv,
    output logic strobe
);

    localparam int             CW   = $clog2(SLOW_DIVIDE + 1);
    localparam logic [CW-1:0]  HALF = CW'(SLOW_DIVIDE / 2);
    localparam logic [CW-1:0]  LAST = CW'(SLOW_DIVIDE - 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic          dv_q;

    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        cnt_eff = (rx_dv && !dv_q) ? '0 : cnt_q;
        cnt_d   = '0;
        if (rx_dv) begin
            cnt_d = (cnt_eff == LAST) ? '0 : cnt_eff + CW'(1);
        end
        strobe = rx_dv && (!slow_mode || (cnt_eff == HALF));
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            dv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dv_q  <= rx_dv;
        end
    end

endmodule

// File: rtl/mii_frame_receiver.sv
// Width-generic PHY receive deframer: strips preamble/SFD, packs sub-words LSB-first into
// bytes, and emits them through a one-byte holdback so the final byte can carry the last tag.
module mii_frame_receiver
    import mii_pkg::*;
#(
    parameter int DATA_WIDTH            = 2,
    parameter int SLOW_DIVIDE           = 10,
    parameter int MAX_FRAME_BYTES       = 1522,
    parameter int MAX_PREAMBLE_SUBWORDS = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  speed_10,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_enable,
    input  logic                  rx_data_error,
    output logic [8:0]            packaged_data,
    output logic                  packaged_data_valid,
    output logic                  frame_error,
    output logic [15:0]           frame_length,
    output logic                  busy
);

    localparam int             SPB       = subwords_per_byte(DATA_WIDTH);
    localparam logic [1:0]     SUB_LAST  = 2'(SPB - 1);
    localparam int             PCW       = $clog2(MAX_PREAMBLE_SUBWORDS + 2);
    localparam logic [PCW-1:0] PRE_LIMIT = PCW'(MAX_PREAMBLE_SUBWORDS);
    localparam logic [15:0]    MAX_BYTES = 16'(MAX_FRAME_BYTES);

    rx_state_e      state_q, state_d;
    logic           speed_q, speed_d;
    logic [7:0]     sr_q, sr_d;
    logic [1:0]     sub_cnt_q, sub_cnt_d;
    logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    logic [15:0]    byte_cnt_q, byte_cnt_d;
    logic [8:0]     pdata_q, pdata_d;
    logic           pvalid_q, pvalid_d;
    logic           ferr_q, ferr_d;
    logic [15:0]    flen_q, flen_d;

    logic           strobe;
    logic           slow_mode;
    logic [7:0]     sr_shift;
    logic           sub_wrap;
    logic [1:0]     sub_next;

    // New sub-word enters at the top, so the first one received ends up in the low bits.
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH+7:0] cat;
        cat = {d, sr};
        return cat[DATA_WIDTH+7:DATA_WIDTH];
    endfunction

    // Speed is live while idle so the very first DV clock already uses the right mode.
    assign slow_mode = (state_q == ST_IDLE) ? speed_10 : speed_q;

    mii_sample_strobe #(
        .SLOW_DIVIDE(SLOW_DIVIDE)
    ) u_strobe (
        .clock    (clock),
        .reset_n  (reset_n),
        .slow_mode(slow_mode),
        .rx_dv    (rx_data_enable),
        .strobe   (strobe)
    );

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        sr_d        = sr_q;
        sub_cnt_d   = sub_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        byte_cnt_d  = byte_cnt_q;
        pdata_d     = pdata_q;
        pvalid_d    = 1'b0;
        ferr_d      = ferr_q;
        flen_d      = flen_q;

        sr_shift = shift_in(sr_q, rx_data);
        sub_wrap = (sub_cnt_q == SUB_LAST);
        sub_next = sub_wrap ? 2'd0 : sub_cnt_q + 2'd1;

        unique case (state_q)
            ST_IDLE: begin
                speed_d   = speed_10;
                sr_d      = '0;
                sub_cnt_d = '0;
                pre_cnt_d = '0;
                if (enable && rx_data_enable) begin
                    state_d = ST_PREAMBLE;
                    if (strobe) begin
                        sr_d      = sr_shift;
                        sub_cnt_d = sub_next;
                        pre_cnt_d = PCW'(1);
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!rx_data_enable) begin
                    state_d = ST_IDLE;
                end else if (rx_data_error) begin
                    state_d = ST_DROP;
                end else if (strobe) begin
                    sr_d      = sr_shift;
                    sub_cnt_d = sub_next;
                    pre_cnt_d = pre_cnt_q + PCW'(1);
                    if (sub_wrap && (sr_shift == SFD_BYTE)) begin
                        state_d     = ST_PAYLOAD;
                        sr_d        = '0;
                        sub_cnt_d   = '0;
                        byte_cnt_d  = '0;
                        hold_full_d = 1'b0;
                    end else if (pre_cnt_q >= PRE_LIMIT) begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!rx_data_enable) begin
                    // Leftover sub-words at DV drop mean the frame ended off a byte boundary.
                    if (hold_full_q) begin
                        pdata_d  = {1'b1, hold_q};
                        pvalid_d = 1'b1;
                        ferr_d   = (sub_cnt_q != 2'd0);
                        flen_d   = byte_cnt_q;
                    end
                    state_d = ST_IDLE;
                end else if (rx_data_error) begin
                    pdata_d  = {1'b1, (hold_full_q ? hold_q : 8'h00)};
                    pvalid_d = 1'b1;
                    ferr_d   = 1'b1;
                    flen_d   = byte_cnt_q;
                    state_d  = ST_DROP;
                end else if (strobe) begin
                    sr_d      = sr_shift;
                    sub_cnt_d = sub_next;
                    if (sub_wrap) begin
                        if (byte_cnt_q >= MAX_BYTES) begin
                            pdata_d  = {1'b1, hold_q};
                            pvalid_d = 1'b1;
                            ferr_d   = 1'b1;
                            flen_d   = byte_cnt_q;
                            state_d  = ST_DROP;
                        end else begin
                            if (hold_full_q) begin
                                pdata_d  = {1'b0, hold_q};
                                pvalid_d = 1'b1;
                            end
                            hold_d      = sr_shift;
                            hold_full_d = 1'b1;
                            if (byte_cnt_q != 16'hFFFF) begin
                                byte_cnt_d = byte_cnt_q + 16'd1;
                            end
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!rx_data_enable) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            speed_q     <= 1'b0;
            sr_q        <= '0;
            sub_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            byte_cnt_q  <= '0;
            pdata_q     <= '0;
            pvalid_q    <= 1'b0;
            ferr_q      <= 1'b0;
            flen_q      <= '0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            sr_q        <= sr_d;
            sub_cnt_q   <= sub_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            byte_cnt_q  <= byte_cnt_d;
            pdata_q     <= pdata_d;
            pvalid_q    <= pvalid_d;
            ferr_q      <= ferr_d;
            flen_q      <= flen_d;
        end
    end

    assign packaged_data       = pdata_q;
    assign packaged_data_valid = pvalid_q;
    assign frame_error         = ferr_q;
    assign frame_length        = flen_q;
    assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mii_frame_receiver.sv
// Directed bench: a 2-bit receiver, a 4-bit receiver and a 2-bit receiver with a 4-byte
// frame limit (sharing the 2-bit stream); emitted bytes are captured and compared.
module tb_mii_frame_receiver;

    typedef struct {
        logic [8:0]  data;
        logic        err;
        logic [15:0] len;
        int          cyc;
    } rec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic speed_10 = 1'b0;

    logic [1:0] rx2 = '0;
    logic       dv2 = 1'b0;
    logic       er2 = 1'b0;
    logic [3:0] rx4 = '0;
    logic       dv4 = 1'b0;
    logic       er4 = 1'b0;

    logic [8:0]  pd2, pd4, pdm;
    logic        pv2, pv4, pvm;
    logic        fe2, fe4, fem;
    logic [15:0] fl2, fl4, flm;
    logic        bz2, bz4, bzm;

    rec_t q2[$];
    rec_t q4[$];
    rec_t qm[$];

    int cyc = 0;
    int end_cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mii_frame_receiver #(.DATA_WIDTH(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .speed_10(speed_10),
        .rx_data(rx2), .rx_data_enable(dv2), .rx_data_error(er2),
        .packaged_data(pd2), .packaged_data_valid(pv2), .frame_error(fe2),
        .frame_length(fl2), .busy(bz2)
    );

    mii_frame_receiver #(.DATA_WIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .speed_10(speed_10),
        .rx_data(rx4), .rx_data_enable(dv4), .rx_data_error(er4),
        .packaged_data(pd4), .packaged_data_valid(pv4), .frame_error(fe4),
        .frame_length(fl4), .busy(bz4)
    );

    mii_frame_receiver #(.DATA_WIDTH(2), .MAX_FRAME_BYTES(4)) dutm (
        .clock(clock), .reset_n(reset_n), .enable(enable), .speed_10(speed_10),
        .rx_data(rx2), .rx_data_enable(dv2), .rx_data_error(er2),
        .packaged_data(pdm), .packaged_data_valid(pvm), .frame_error(fem),
        .frame_length(flm), .busy(bzm)
    );

    always @(negedge clock) begin
        if (pv2) q2.push_back('{data: pd2, err: fe2, len: fl2, cyc: cyc});
        if (pv4) q4.push_back('{data: pd4, err: fe4, len: fl4, cyc: cyc});
        if (pvm) qm.push_back('{data: pdm, err: fem, len: flm, cyc: cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_t pick(input rec_t q[$], input int i);
        rec_t r;
        r = '{data: 9'h1FF, err: 1'b0, len: 16'hFFFF, cyc: -1000};
        if (i < q.size()) r = q[i];
        return r;
    endfunction

    task automatic sub2(input logic [1:0] d, input int hold);
        rx2 = d;
        dv2 = 1'b1;
        repeat (hold) @(negedge clock);
    endtask

    task automatic byte2(input logic [7:0] b, input int hold);
        for (int i = 0; i < 4; i++) sub2(b[2*i +: 2], hold);
    endtask

    task automatic pre2(input int hold);
        for (int i = 0; i < 7; i++) byte2(8'h55, hold);
        byte2(8'hD5, hold);
    endtask

    task automatic end2();
        dv2 = 1'b0;
        er2 = 1'b0;
        rx2 = '0;
        end_cyc = cyc;
        repeat (4) @(negedge clock);
    endtask

    task automatic sub4(input logic [3:0] d);
        rx4 = d;
        dv4 = 1'b1;
        @(negedge clock);
    endtask

    task automatic byte4(input logic [7:0] b);
        sub4(b[3:0]);
        sub4(b[7:4]);
    endtask

    initial begin
        int b2;
        int bm;
        rec_t r;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_data",  32'(pd2), 32'h0);
        check("rst_valid", 32'(pv2), 32'h0);
        check("rst_err",   32'(fe2), 32'h0);
        check("rst_len",   32'(fl2), 32'h0);
        check("rst_busy",  32'(bz2), 32'h0);

        // Frame 01 02 03; enable dropped after the SFD must not abort it.
        enable = 1'b1;
        b2 = q2.size();
        pre2(1);
        enable = 1'b0;
        byte2(8'h01, 1); byte2(8'h02, 1); byte2(8'h03, 1);
        end2();
        check("t1_count", 32'(q2.size() - b2), 32'd3);
        check("t1_b0", 32'(pick(q2, b2).data), 32'h001);
        check("t1_b1", 32'(pick(q2, b2 + 1).data), 32'h002);
        r = pick(q2, b2 + 2);
        check("t1_b2", 32'(r.data), 32'h103);
        check("t1_err", 32'(r.err), 32'h0);
        check("t1_len", 32'(r.len), 32'd3);
        check("t1_last_lat", 32'(r.cyc - end_cyc), 32'd1);
        check("t1_byte_gap", 32'(pick(q2, b2 + 1).cyc - pick(q2, b2).cyc), 32'd4);
        check("t1_idle", 32'(bz2), 32'h0);

        // Same frame with enable still low: must be ignored.
        b2 = q2.size();
        pre2(1);
        byte2(8'h01, 1);
        check("en_off_busy", 32'(bz2), 32'h0);
        end2();
        check("en_off_count", 32'(q2.size() - b2), 32'd0);
        enable = 1'b1;

        // 10 Mb/s mode, every dibit held 10 clocks.
        speed_10 = 1'b1;
        b2 = q2.size();
        pre2(10);
        byte2(8'h01, 10); byte2(8'h02, 10); byte2(8'h03, 10);
        end2();
        speed_10 = 1'b0;
        check("t2_count", 32'(q2.size() - b2), 32'd3);
        check("t2_b0", 32'(pick(q2, b2).data), 32'h001);
        check("t2_b1", 32'(pick(q2, b2 + 1).data), 32'h002);
        check("t2_b2", 32'(pick(q2, b2 + 2).data), 32'h103);
        check("t2_gap", 32'(pick(q2, b2 + 1).cyc - pick(q2, b2).cyc), 32'd40);
        check("t2_len", 32'(pick(q2, b2 + 2).len), 32'd3);

        // 4-bit PHY, receive error while CC arrives.
        for (int i = 0; i < 7; i++) byte4(8'h55);
        byte4(8'hD5);
        byte4(8'hAA); byte4(8'hBB);
        er4 = 1'b1;
        sub4(4'hC);
        er4 = 1'b0;
        sub4(4'hC);
        byte4(8'hDD);
        check("t3_drop_busy", 32'(bz4), 32'h1);
        dv4 = 1'b0;
        repeat (4) @(negedge clock);
        check("t3_count", 32'(q4.size()), 32'd2);
        check("t3_b0", 32'(pick(q4, 0).data), 32'h0AA);
        r = pick(q4, 1);
        check("t3_b1", 32'(r.data), 32'h1BB);
        check("t3_err", 32'(r.err), 32'h1);
        check("t3_len", 32'(r.len), 32'd2);

        // Frame ending three dibits into a fourth byte.
        b2 = q2.size();
        pre2(1);
        byte2(8'h11, 1); byte2(8'h22, 1); byte2(8'h33, 1);
        sub2(2'b00, 1); sub2(2'b01, 1); sub2(2'b00, 1);
        end2();
        check("t4_count", 32'(q2.size() - b2), 32'd3);
        check("t4_b0", 32'(pick(q2, b2).data), 32'h011);
        check("t4_b1", 32'(pick(q2, b2 + 1).data), 32'h022);
        r = pick(q2, b2 + 2);
        check("t4_b2", 32'(r.data), 32'h133);
        check("t4_err", 32'(r.err), 32'h1);
        check("t4_len", 32'(r.len), 32'd3);

        // Six bytes against a 4-byte limit; the 2-bit receiver sees a normal frame.
        b2 = q2.size();
        bm = qm.size();
        pre2(1);
        for (int i = 1; i <= 6; i++) byte2(8'(i), 1);
        end2();
        check("t5_count", 32'(qm.size() - bm), 32'd4);
        check("t5_b0", 32'(pick(qm, bm).data), 32'h001);
        check("t5_b1", 32'(pick(qm, bm + 1).data), 32'h002);
        check("t5_b2", 32'(pick(qm, bm + 2).data), 32'h003);
        r = pick(qm, bm + 3);
        check("t5_b3", 32'(r.data), 32'h104);
        check("t5_err", 32'(r.err), 32'h1);
        check("t5_len", 32'(r.len), 32'd4);
        r = pick(q2, b2 + 5);
        check("t5_ref_last", 32'(r.data), 32'h106);
        check("t5_ref_len", 32'(r.len), 32'd6);
        check("t5_ref_err", 32'(r.err), 32'h0);

        bm = qm.size();
        pre2(1);
        byte2(8'h07, 1); byte2(8'h08, 1);
        end2();
        check("t5_next_count", 32'(qm.size() - bm), 32'd2);
        check("t5_next_b0", 32'(pick(qm, bm).data), 32'h007);
        r = pick(qm, bm + 1);
        check("t5_next_b1", 32'(r.data), 32'h108);
        check("t5_next_err", 32'(r.err), 32'h0);
        check("t5_next_len", 32'(r.len), 32'd2);

        // Endless preamble: dropped, busy until DV falls, nothing emitted.
        b2 = q2.size();
        for (int i = 0; i < 80; i++) sub2(2'b01, 1);
        check("t6_pre_busy", 32'(bz2), 32'h1);
        end2();
        check("t6_pre_count", 32'(q2.size() - b2), 32'd0);
        check("t6_pre_idle", 32'(bz2), 32'h0);

        // Reset in the middle of a payload.
        b2 = q2.size();
        pre2(1);
        byte2(8'h01, 1); byte2(8'h02, 1); byte2(8'h03, 1);
        reset_n = 1'b0;
        dv2 = 1'b0;
        #1;
        check("t6_rst_data",  32'(pd2), 32'h0);
        check("t6_rst_valid", 32'(pv2), 32'h0);
        check("t6_rst_len",   32'(fl2), 32'h0);
        check("t6_rst_busy",  32'(bz2), 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("t6_rst_count", 32'(q2.size() - b2), 32'd2);
        check("t6_rst_err", 32'(fe2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
